sqrt_unit_param: RTL and testbench

SQRT_UNIT_PARAM -- requirements
Module: sqrt_unit_param

---
 rtl/sqrt_unit_param.sv | 163 ++++++++++++++++
 tb/tb_sqrt_unit_param.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/sqrt_unit_param.sv
// sqrt_unit_param
//   Restoring digit-by-digit integer square root with a 2x16 LCD text front end.
//   Flow: IDLE -> (next & enable) -> LOAD -> (next, samples data_in) -> CALC
//         (WIDTH/2 cycles, one root bit per cycle) -> DONE -> (next) -> IDLE.
//
// Ports
//   Clk        : single clock, rising-edge
//   reset      : synchronous, active-high
//   data_in    : WIDTH-bit unsigned radicand, sampled on the LOAD->CALC edge
//   enable     : block selected by the top-level menu (only gates IDLE->LOAD)
//   next       : one-cycle debounced button pulse
//   root       : floor(sqrt(radicand)), WIDTH/2 bits
//   remainder  : radicand - root*root, WIDTH/2+1 bits
//   exact      : remainder == 0
//   busy       : high while in CALC
//   done       : high while in DONE
//   textOut    : 32 ASCII characters, char 0 in bits 255:248
module sqrt_unit_param #(
  parameter int WIDTH = 16
) (
  input  logic               Clk,
  input  logic               reset,
  input  logic [WIDTH-1:0]   data_in,
  input  logic               enable,
  input  logic               next,
  output logic [WIDTH/2-1:0] root,
  output logic [WIDTH/2:0]   remainder,
  output logic               exact,
  output logic               busy,
  output logic               done,
  output logic [255:0]       textOut
);

  localparam int H  = WIDTH / 2;       // root width / iteration count
  localparam int RW = H + 2;           // working remainder width
  localparam int CW = $clog2(H + 1);   // iteration counter width

  localparam logic [3:0] S_IDLE = 4'b0001;
  localparam logic [3:0] S_LOAD = 4'b0010;
  localparam logic [3:0] S_CALC = 4'b0100;
  localparam logic [3:0] S_DONE = 4'b1000;

  localparam logic [255:0] TXT_IDLE = {"Square Root     ", "Sqrts a Number  "};
  localparam logic [255:0] TXT_LOAD = {"Input #         ", "Then Press Btnc "};
  localparam logic [255:0] TXT_CALC = {"Calculating...  ", "                "};

  logic [3:0]       state_q, state_d;
  logic [WIDTH-1:0] operand_q, operand_d;
  logic [H-1:0]     root_q, root_d;       // partial root during CALC
  logic [RW-1:0]    rem_q, rem_d;         // partial remainder during CALC
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [H-1:0]     root_out_q, root_out_d;
  logic [H:0]       rem_out_q, rem_out_d;
  logic             exact_q, exact_d;

  logic [RW-1:0]    rem_shift, trial, rem_step;
  logic [H-1:0]     root_step;

  // One restoring iteration. The partial remainder never exceeds 2*root,
  // so the shifted value and the trial both fit in H+2 bits.
  always_comb begin
    rem_shift = (rem_q << 2) | {{(RW-2){1'b0}}, operand_q[WIDTH-1 -: 2]};
    trial     = {root_q, 2'b01};
    if (rem_shift >= trial) begin
      rem_step  = rem_shift - trial;
      root_step = {root_q[H-2:0], 1'b1};
    end else begin
      rem_step  = rem_shift;
      root_step = {root_q[H-2:0], 1'b0};
    end
  end

  always_comb begin
    state_d    = state_q;
    operand_d  = operand_q;
    root_d     = root_q;
    rem_d      = rem_q;
    cnt_d      = cnt_q;
    root_out_d = root_out_q;
    rem_out_d  = rem_out_q;
    exact_d    = exact_q;
    case (state_q)
      S_IDLE: begin
        if (next && enable) state_d = S_LOAD;
      end
      S_LOAD: begin
        if (next) begin
          operand_d = data_in;
          root_d    = '0;
          rem_d     = '0;
          cnt_d     = CW'(H);
          state_d   = S_CALC;
        end
      end
      S_CALC: begin
        // operand is consumed two bits at a time from the top
        operand_d = operand_q << 2;
        root_d    = root_step;
        rem_d     = rem_step;
        cnt_d     = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          // results are published only on entry to DONE
          root_out_d = root_step;
          rem_out_d  = rem_step[H:0];
          exact_d    = (rem_step == '0);
          state_d    = S_DONE;
        end
      end
      S_DONE: begin
        if (next) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      operand_q  <= '0;
      root_q     <= '0;
      rem_q      <= '0;
      cnt_q      <= '0;
      root_out_q <= '0;
      rem_out_q  <= '0;
      exact_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      operand_q  <= operand_d;
      root_q     <= root_d;
      rem_q      <= rem_d;
      cnt_q      <= cnt_d;
      root_out_q <= root_out_d;
      rem_out_q  <= rem_out_d;
      exact_q    <= exact_d;
    end
  end

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    if (n < 4'd10) return 8'h30 + {4'b0, n};
    else           return 8'h37 + {4'b0, n};
  endfunction

  function automatic logic [31:0] hex4(input logic [15:0] v);
    return {hex_char(v[15:12]), hex_char(v[11:8]), hex_char(v[7:4]), hex_char(v[3:0])};
  endfunction

  always_comb begin
    case (state_q)
      S_LOAD:  textOut = TXT_LOAD;
      S_CALC:  textOut = TXT_CALC;
      S_DONE:  textOut = {"Root: ", hex4(16'(root_out_q)), "      ",
                          "Rem:  ", hex4(16'(rem_out_q)),  "      "};
      default: textOut = TXT_IDLE;
    endcase
  end

  assign root      = root_out_q;
  assign remainder = rem_out_q;
  assign exact     = exact_q;
  assign busy      = (state_q == S_CALC);
  assign done      = (state_q == S_DONE);

endmodule

// File: tb/tb_sqrt_unit_param.sv
// Directed bench for sqrt_unit_param: one WIDTH=8 and one WIDTH=16 instance.
module tb_sqrt_unit_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // WIDTH=8 instance
  logic       reset8, en8, nx8;
  logic [7:0] din8;
  logic [3:0] root8;
  logic [4:0] rem8;
  logic       exact8, busy8, done8;
  logic [255:0] text8;

  // WIDTH=16 instance
  logic        reset16, en16, nx16;
  logic [15:0] din16;
  logic [7:0]  root16;
  logic [8:0]  rem16;
  logic        exact16, busy16, done16;
  logic [255:0] text16;

  sqrt_unit_param #(.WIDTH(8)) u_dut8 (
    .Clk(clk), .reset(reset8), .data_in(din8), .enable(en8), .next(nx8),
    .root(root8), .remainder(rem8), .exact(exact8), .busy(busy8),
    .done(done8), .textOut(text8)
  );

  sqrt_unit_param #(.WIDTH(16)) u_dut16 (
    .Clk(clk), .reset(reset16), .data_in(din16), .enable(en16), .next(nx16),
    .root(root16), .remainder(rem16), .exact(exact16), .busy(busy16),
    .done(done16), .textOut(text16)
  );

  localparam logic [255:0] T_IDLE = {"Square Root     ", "Sqrts a Number  "};
  localparam logic [255:0] T_LOAD = {"Input #         ", "Then Press Btnc "};
  localparam logic [255:0] T_CALC = {"Calculating...  ", "                "};

  int n_vec = 0;
  int n_err = 0;

  // selects which instance the helper tasks drive and observe
  bit sel16 = 1'b0;
  logic         o_busy, o_done, o_exact;
  logic [7:0]   o_root;
  logic [8:0]   o_rem;
  logic [255:0] o_text;
  assign o_busy  = sel16 ? busy16  : busy8;
  assign o_done  = sel16 ? done16  : done8;
  assign o_exact = sel16 ? exact16 : exact8;
  assign o_root  = sel16 ? root16  : {4'b0, root8};
  assign o_rem   = sel16 ? rem16   : {4'b0, rem8};
  assign o_text  = sel16 ? text16  : text8;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic en, input logic nx, input logic [15:0] d);
    if (sel16) begin en16 = en; nx16 = nx; din16 = d; end
    else       begin en8 = en;  nx8 = nx;  din8 = d[7:0]; end
  endtask

  // IDLE -> LOAD -> CALC, then count busy cycles (bounded). With disturb set,
  // next/enable/data_in are wiggled throughout CALC.
  task automatic run(input logic [15:0] v, input bit disturb, output int nbusy);
    drive(1'b1, 1'b1, v);
    cycle();
    chk("load_text", o_text, T_LOAD);
    cycle();                              // edge that samples next and data_in
    drive(1'b1, 1'b0, disturb ? ~v : v);
    chk("calc_text", o_text, T_CALC);
    nbusy = 0;
    while (o_busy && nbusy < 20) begin
      if (disturb) drive(nbusy[0], 1'b1, 16'($urandom));
      nbusy++;
      cycle();
    end
    drive(1'b1, 1'b0, v);
    $display("txn w%0d radicand %0d -> root %0d rem %0d exact %0d busy_cycles %0d",
             sel16 ? 16 : 8, v, o_root, o_rem, o_exact, nbusy);
  endtask

  task automatic expect_result(input string tag, input int nbusy, input int exp_busy,
                               input logic [7:0] r, input logic [8:0] m,
                               input logic ex, input logic [255:0] txt);
    chk({tag, "_busy_cycles"}, 256'(nbusy), 256'(exp_busy));
    chk({tag, "_done"},  256'(o_done),  256'(1'b1));
    chk({tag, "_root"},  256'(o_root),  256'(r));
    chk({tag, "_rem"},   256'(o_rem),   256'(m));
    chk({tag, "_exact"}, 256'(o_exact), 256'(ex));
    chk({tag, "_text"},  o_text, txt);
  endtask

  int nb;

  initial begin
    reset8 = 1'b1; reset16 = 1'b1;
    en8 = 0; nx8 = 0; din8 = 0;
    en16 = 0; nx16 = 0; din16 = 0;
    @(negedge clk);
    cycle();
    cycle();
    sel16 = 1'b1;
    chk("rst_root",  256'(o_root),  256'(0));
    chk("rst_rem",   256'(o_rem),   256'(0));
    chk("rst_exact", 256'(o_exact), 256'(0));
    chk("rst_busy",  256'(o_busy),  256'(0));
    chk("rst_done",  256'(o_done),  256'(0));
    chk("rst_text",  o_text, T_IDLE);
    chk("rst_text8", text8,  T_IDLE);
    reset8 = 1'b0; reset16 = 1'b0;
    cycle();

    // ---- WIDTH=8 ----
    sel16 = 1'b0;
    run(16'd144, 1'b0, nb);
    expect_result("w8_144", nb, 4, 8'h0C, 9'h000, 1'b1,
                  {"Root: 000C      ", "Rem:  0000      "});
    // DONE -> IDLE on next without enable; results hold in IDLE
    drive(1'b0, 1'b1, 16'd0);
    cycle();
    drive(1'b0, 1'b0, 16'd0);
    chk("w8_done_exit", 256'(o_done), 256'(0));
    chk("w8_idle_text", o_text, T_IDLE);
    chk("w8_hold_root", 256'(o_root), 256'(8'h0C));

    run(16'd255, 1'b1, nb);
    expect_result("w8_255", nb, 4, 8'h0F, 9'h01E, 1'b0,
                  {"Root: 000F      ", "Rem:  001E      "});
    drive(1'b1, 1'b1, 16'd0);
    cycle();
    // next with enable low in IDLE must not leave IDLE
    drive(1'b0, 1'b1, 16'd0);
    cycle();
    cycle();
    drive(1'b0, 1'b0, 16'd0);
    chk("w8_noen_text", o_text, T_IDLE);
    chk("w8_noen_busy", 256'(o_busy), 256'(0));

    // ---- WIDTH=16 ----
    sel16 = 1'b1;
    run(16'd0, 1'b0, nb);
    expect_result("w16_0", nb, 8, 8'h00, 9'h000, 1'b1,
                  {"Root: 0000      ", "Rem:  0000      "});
    drive(1'b1, 1'b1, 16'd0);
    cycle();
    run(16'd65535, 1'b0, nb);
    expect_result("w16_ffff", nb, 8, 8'hFF, 9'h1FE, 1'b0,
                  {"Root: 00FF      ", "Rem:  01FE      "});
    drive(1'b1, 1'b1, 16'd0);
    cycle();

    // reset during the 3rd CALC cycle, with next held high on the same edge
    drive(1'b1, 1'b1, 16'd1234);
    cycle();
    cycle();
    drive(1'b1, 1'b0, 16'd1234);
    chk("w16_mid_busy", 256'(o_busy), 256'(1));
    cycle();
    cycle();
    reset16 = 1'b1;
    drive(1'b1, 1'b1, 16'd1234);
    cycle();
    reset16 = 1'b0;
    drive(1'b0, 1'b0, 16'd0);
    chk("w16_rst_text",  o_text, T_IDLE);
    chk("w16_rst_busy",  256'(o_busy),  256'(0));
    chk("w16_rst_done",  256'(o_done),  256'(0));
    chk("w16_rst_root",  256'(o_root),  256'(0));
    chk("w16_rst_rem",   256'(o_rem),   256'(0));
    chk("w16_rst_exact", 256'(o_exact), 256'(0));

    run(16'd10000, 1'b1, nb);
    expect_result("w16_10000", nb, 8, 8'h64, 9'h000, 1'b1,
                  {"Root: 0064      ", "Rem:  0000      "});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
